// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time byte-stream loader that fills instruction memory
//
// Purpose: receives a little-endian image (4-byte word count N, N 4-byte words,
// one XOR checksum byte over the payload), writes each word into instruction
// memory, and holds the core in reset until the image is verified.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   in_valid      in_data holds a byte
//   in_data       stream byte
//   in_ready      loader can accept a byte (decoded from state)
//   mem_waddress  instruction memory write address (byte address)
//   mem_datain    instruction memory write data
//   mem_wr        instruction memory write strobe, one cycle per word
//   cpu_hold      keeps the core in reset until the image is verified
//   done          image loaded and verified (sticky)
//   error         load failed (sticky)
//
// Optional feature: define LOADER_TIMEOUT_EN to abort to ERROR after
// TIMEOUT_CYCLES idle cycles in the middle of an image.

module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_waddress,
  output logic [31:0] mem_datain,
  output logic        mem_wr,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HDR, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;       // first three bytes of the current header/word
  logic [31:0] word_count;
  logic [31:0] idx;
  logic [7:0]  checksum;
  logic        accept;
  logic        last_byte;
  logic [31:0] assembled;
  logic        timeout_hit;

  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // Full little-endian word as it stands once the 4th byte arrives.
  assign assembled = {in_data, shift};

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        idle_counting;

  // The header is only "in progress" once its first byte has arrived.
  assign idle_counting = (state == S_PAYLOAD) || (state == S_CHECK) ||
                         ((state == S_HDR) && (byte_cnt != 2'd0));
  assign timeout_hit   = idle_counting && !accept &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= 32'd0;
    end else if (accept || !idle_counting) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_HDR: begin
        if (accept && last_byte) begin
          if (assembled == 32'd0)                   state_next = S_CHECK;
          else if (assembled > 32'(MAX_WORDS))      state_next = S_ERROR;
          else                                      state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (accept && last_byte) state_next = S_WRITE;
      S_WRITE:   state_next = ((idx + 32'd1) == word_count) ? S_CHECK : S_PAYLOAD;
      S_CHECK:   if (accept) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
      S_DONE:    state_next = S_DONE;
      S_ERROR:   state_next = S_ERROR;
      default:   state_next = S_ERROR;
    endcase
    if (timeout_hit) state_next = S_ERROR;
  end

  // Output decode
  always_comb begin
    in_ready = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_CHECK);
    mem_wr   = (state == S_WRITE);
    done     = (state == S_DONE);
    error    = (state == S_ERROR);
    cpu_hold = (state != S_DONE);
  end

  // Datapath: byte assembly, checksum, write address/data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
      word_count   <= 32'd0;
      idx          <= 32'd0;
      checksum     <= 8'd0;
      mem_waddress <= BASE_ADDR;
      mem_datain   <= 32'd0;
    end else begin
      if (accept && ((state == S_HDR) || (state == S_PAYLOAD))) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {in_data, shift[23:8]};
      end
      if (accept && (state == S_HDR) && last_byte) begin
        word_count <= assembled;
      end
      if (accept && (state == S_PAYLOAD)) begin
        checksum <= checksum ^ in_data;
        if (last_byte) begin
          // Held until the next word completes, so memory sees stable values.
          mem_datain   <= assembled;
          mem_waddress <= BASE_ADDR + (idx << 2);
        end
      end
      if (state == S_WRITE) begin
        idx <= idx + 32'd1;
      end
    end
  end

endmodule
